circle_point_scheduler: RTL

Multi-channel sequencer that time-shares one `circle_fsm_32bit_simple` point generator among `NUM_CH` independent low-discrepancy streams. Each channel owns a running index `k` and a base select. The scheduler round-robin arbitrates pending channel requests, drives the core's start/k/base_sel handshake, captures the (x, y) Q16.16 result, and presents it on a valid/ready output stream tagged with channel and index. It sits between the point consumers and the circle core.

---
 rtl/circle_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/circle_point_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/circle_pkg.sv
// Shared constants and types for the circle point generator and its scheduler.
package circle_pkg;

  localparam logic [31:0] FX_ONE = 32'h0001_0000;

  localparam logic [1:0] BASE_2 = 2'b00;
  localparam logic [1:0] BASE_3 = 2'b01;
  localparam logic [1:0] BASE_5 = 2'b10;
  localparam logic [1:0] BASE_7 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } sched_state_t;

  // Index 0 is reserved for explicit seeding, so the all-ones index wraps to 1.
  function automatic logic [31:0] next_index(input logic [31:0] k);
    return (k == 32'hFFFF_FFFF) ? 32'd1 : k + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request strictly after the pointer.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   pointer,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx
);

  logic [CH_W-1:0] cand;
  logic            found;

  // NUM_CH is a power of two, so truncating pointer+i to CH_W bits wraps naturally.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = pointer + CH_W'(i);
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/circle_point_scheduler.sv
// Time-shares one circle point core among NUM_CH index streams with round-robin
// arbitration and a valid/ready tagged result output.
module circle_point_scheduler
  import circle_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = $clog2(NUM_CH),
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              seed_we,
  input  logic [CH_W-1:0]   seed_ch,
  input  logic [31:0]       seed_k,
  input  logic [1:0]        seed_base,
  output logic              core_start,
  output logic [31:0]       core_k,
  output logic [1:0]        core_base_sel,
  input  logic              core_ready,
  input  logic              core_done,
  input  logic [31:0]       core_x,
  input  logic [31:0]       core_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [31:0]       out_k,
  output logic [31:0]       out_x,
  output logic [31:0]       out_y,
  output logic              err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  sched_state_t      state;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   ptr;
  logic [WD_W-1:0]   wd;
  logic              seeded;
  logic [31:0]       k_mem    [NUM_CH];
  logic [1:0]        base_mem [NUM_CH];

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;
  logic              seed_hit;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req     (req),
    .pointer (ptr),
    .enable  (state == ST_IDLE),
    .grant   (grant),
    .idx     (grant_idx)
  );

  assign grant_any  = |grant;
  assign seed_hit   = seed_we && (seed_ch == cur_ch);
  assign core_start = (state == ST_ISSUE) && core_ready;
  assign out_valid  = (state == ST_OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cur_ch        <= '0;
      ptr           <= CH_W'(NUM_CH - 1);
      wd            <= '0;
      seeded        <= 1'b0;
      core_k        <= '0;
      core_base_sel <= '0;
      out_ch        <= '0;
      out_k         <= '0;
      out_x         <= '0;
      out_y         <= '0;
      err_timeout   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        k_mem[i]    <= 32'd1;
        base_mem[i] <= BASE_2;
      end
    end else begin
      // A seed to the channel already in flight must survive the later accept.
      if (state != ST_IDLE && seed_hit)
        seeded <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            cur_ch        <= grant_idx;
            ptr           <= grant_idx;
            core_k        <= k_mem[grant_idx];
            core_base_sel <= base_mem[grant_idx];
            seeded        <= seed_we && (seed_ch == grant_idx);
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (core_ready) begin
            wd    <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (core_done) begin
            out_x  <= core_x;
            out_y  <= core_y;
            out_ch <= cur_ch;
            out_k  <= core_k;
            state  <= ST_OUT;
          end else if (wd == WD_MAX) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (!seeded && !seed_hit)
              k_mem[cur_ch] <= next_index(k_mem[cur_ch]);
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (seed_we) begin
        k_mem[seed_ch]    <= seed_k;
        base_mem[seed_ch] <= seed_base;
      end
    end
  end

endmodule
